// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - fetch sequencer control, instruction-memory and decoder bundle
//
// Signals:
//   i_stall, i_branch_taken, i_branch_target   pipeline control into the sequencer
//   o_pc                                       PC of the instruction fetched or held
//   o_imem_req, o_imem_addr                    instruction-memory fetch request
//   i_imem_ack, i_imem_data                    instruction-memory completion
//   o_instr, o_instr_valid, i_instr_ready      decoder handshake
// Modports:
//   slave   the sequencer itself
//   master  the surrounding pipeline / memory / decoder
interface pc_sequencer_if;
  logic        i_stall;
  logic        i_branch_taken;
  logic [63:0] i_branch_target;
  logic [63:0] o_pc;
  logic        o_imem_req;
  logic [63:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_data;
  logic [31:0] o_instr;
  logic        o_instr_valid;
  logic        i_instr_ready;

  modport slave (
    input  i_stall, i_branch_taken, i_branch_target,
    input  i_imem_ack, i_imem_data, i_instr_ready,
    output o_pc, o_imem_req, o_imem_addr, o_instr, o_instr_valid
  );

  modport master (
    output i_stall, i_branch_taken, i_branch_target,
    output i_imem_ack, i_imem_data, i_instr_ready,
    input  o_pc, o_imem_req, o_imem_addr, o_instr, o_instr_valid
  );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter and instruction fetch sequencer
//
// Ports:
//   i_clk   single clock, rising edge
//   i_rst   asynchronous active-high reset
//   bus     pc_sequencer_if.slave: control, instruction memory and decoder
// Parameters:
//   RESET_VECTOR  PC and fetch address loaded on reset
module pc_sequencer #(
  parameter logic [63:0] RESET_VECTOR = 64'h0
) (
  input  logic           i_clk,
  input  logic           i_rst,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_VALID = 2'd2
  } state_t;

  state_t      state;
  logic [63:0] pc_q;
  logic [63:0] addr_q;
  logic        req_q;
  logic [31:0] instr_q;
  logic        valid_q;
  // Set when the outstanding request was issued for a PC that has since been
  // redirected; its returning data must be dropped and the fetch re-issued.
  logic        squash_q;

  logic [63:0] target_pc;
  logic [63:0] seq_pc;

  assign target_pc = bus.i_branch_target & ~64'h3;
  assign seq_pc    = pc_q + 64'd4;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      pc_q     <= RESET_VECTOR;
      addr_q   <= RESET_VECTOR;
      req_q    <= 1'b0;
      instr_q  <= 32'h0;
      valid_q  <= 1'b0;
      squash_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Any ack seen here belongs to a request abandoned by reset.
          state <= ST_REQ;
          req_q <= 1'b1;
          if (bus.i_branch_taken) begin
            pc_q   <= target_pc;
            addr_q <= target_pc;
          end else begin
            addr_q <= pc_q;
          end
        end

        ST_REQ: begin
          if (bus.i_branch_taken) begin
            pc_q <= target_pc;
            if (bus.i_imem_ack) begin
              // Old fetch completes as we redirect: drop it, fetch target next.
              squash_q <= 1'b0;
              addr_q   <= target_pc;
            end else begin
              // Address must stay stable until the memory answers.
              squash_q <= 1'b1;
            end
          end else if (bus.i_imem_ack) begin
            if (squash_q) begin
              squash_q <= 1'b0;
              addr_q   <= pc_q;
            end else begin
              instr_q <= bus.i_imem_data;
              valid_q <= 1'b1;
              req_q   <= 1'b0;
              state   <= ST_VALID;
            end
          end
        end

        ST_VALID: begin
          if (bus.i_branch_taken) begin
            pc_q    <= target_pc;
            addr_q  <= target_pc;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state   <= ST_REQ;
          end else if (!bus.i_stall && bus.i_instr_ready) begin
            pc_q    <= seq_pc;
            addr_q  <= seq_pc;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state   <= ST_REQ;
          end
        end

        default: begin
          state <= ST_IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_pc          = pc_q;
  assign bus.o_imem_req    = req_q;
  assign bus.o_imem_addr   = addr_q;
  assign bus.o_instr       = instr_q;
  assign bus.o_instr_valid = valid_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  localparam logic [63:0] WRAP_VECTOR = 64'hFFFF_FFFF_FFFF_FFFC;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  pc_sequencer_if bus0 ();
  pc_sequencer_if bus1 ();

  pc_sequencer #(.RESET_VECTOR(64'h0)) dut0 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus0)
  );

  pc_sequencer #(.RESET_VECTOR(WRAP_VECTOR)) dut1 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst = 1'b0;
    bus0.i_stall = 1'b0; bus0.i_branch_taken = 1'b0; bus0.i_branch_target = 64'h0;
    bus0.i_imem_ack = 1'b0; bus0.i_imem_data = 32'h0; bus0.i_instr_ready = 1'b0;
    bus1.i_stall = 1'b0; bus1.i_branch_taken = 1'b0; bus1.i_branch_target = 64'h0;
    bus1.i_imem_ack = 1'b0; bus1.i_imem_data = 32'h0; bus1.i_instr_ready = 1'b0;

    // Reset, applied before any clock edge
    #1 rst = 1'b1;
    #1;
    check("rst_pc",     bus0.o_pc, 64'h0);
    check("rst_addr",   bus0.o_imem_addr, 64'h0);
    check("rst_req",    bus0.o_imem_req, 0);
    check("rst_valid",  bus0.o_instr_valid, 0);
    check("rst_instr",  bus0.o_instr, 0);
    check("rst_pc_wrap", bus1.o_pc, WRAP_VECTOR);
    rst = 1'b0;

    // Sequential fetch, ack one cycle after each request, ready high
    tick();
    bus0.i_instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("seq%0d_req", i),   bus0.o_imem_req, 1);
      check($sformatf("seq%0d_addr", i),  bus0.o_imem_addr, 64'(4 * i));
      check($sformatf("seq%0d_nval", i),  bus0.o_instr_valid, 0);
      bus0.i_imem_ack = 1'b1;
      bus0.i_imem_data = 32'hA000_0000 + 32'(i);
      tick();
      bus0.i_imem_ack = 1'b0;
      check($sformatf("seq%0d_valid", i), bus0.o_instr_valid, 1);
      check($sformatf("seq%0d_instr", i), bus0.o_instr, 64'hA000_0000 + 64'(i));
      check($sformatf("seq%0d_pc", i),    bus0.o_pc, 64'(4 * i));
      tick();
    end
    check("seq_next_addr", bus0.o_imem_addr, 64'h10);
    check("seq_next_pc",   bus0.o_pc, 64'h10);

    // Stall in VALID with ready high holds everything
    bus0.i_instr_ready = 1'b0;
    bus0.i_imem_ack = 1'b1; bus0.i_imem_data = 32'hD4D4_D4D4;
    tick();
    bus0.i_imem_ack = 1'b0;
    bus0.i_stall = 1'b1; bus0.i_instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall%0d_pc", i),    bus0.o_pc, 64'h10);
      check($sformatf("stall%0d_instr", i), bus0.o_instr, 64'hD4D4_D4D4);
      check($sformatf("stall%0d_valid", i), bus0.o_instr_valid, 1);
    end
    bus0.i_stall = 1'b0;
    tick();
    bus0.i_instr_ready = 1'b0;
    check("unstall_addr",  bus0.o_imem_addr, 64'h14);
    check("unstall_pc",    bus0.o_pc, 64'h14);
    check("unstall_valid", bus0.o_instr_valid, 0);

    // Redirect to 0x1003 while fetch of 0x14 outstanding, ack 3 cycles later
    bus0.i_branch_taken = 1'b1; bus0.i_branch_target = 64'h1003;
    tick();
    bus0.i_branch_taken = 1'b0;
    check("sq_pc",   bus0.o_pc, 64'h1000);
    check("sq_addr_held", bus0.o_imem_addr, 64'h14);
    tick();
    tick();
    bus0.i_imem_ack = 1'b1; bus0.i_imem_data = 32'hDEAD_0014;
    tick();
    bus0.i_imem_ack = 1'b0;
    check("sq_drop_valid", bus0.o_instr_valid, 0);
    check("sq_refetch",    bus0.o_imem_addr, 64'h1000);
    check("sq_refetch_req", bus0.o_imem_req, 1);
    bus0.i_imem_ack = 1'b1; bus0.i_imem_data = 32'hC000_1000;
    tick();
    bus0.i_imem_ack = 1'b0;
    check("sq_valid", bus0.o_instr_valid, 1);
    check("sq_instr", bus0.o_instr, 64'hC000_1000);
    check("sq_pc2",   bus0.o_pc, 64'h1000);

    // Two redirects while one fetch is outstanding
    bus0.i_instr_ready = 1'b1;
    tick();
    bus0.i_instr_ready = 1'b0;
    check("dbl_addr0", bus0.o_imem_addr, 64'h1004);
    bus0.i_branch_taken = 1'b1; bus0.i_branch_target = 64'h3000;
    tick();
    bus0.i_branch_target = 64'h4008;
    tick();
    bus0.i_branch_taken = 1'b0;
    check("dbl_pc",   bus0.o_pc, 64'h4008);
    check("dbl_addr", bus0.o_imem_addr, 64'h1004);
    bus0.i_imem_ack = 1'b1; bus0.i_imem_data = 32'hBAD1_1004;
    tick();
    bus0.i_imem_ack = 1'b0;
    check("dbl_drop",    bus0.o_instr_valid, 0);
    check("dbl_refetch", bus0.o_imem_addr, 64'h4008);
    bus0.i_imem_ack = 1'b1; bus0.i_imem_data = 32'hC001_4008;
    tick();
    bus0.i_imem_ack = 1'b0;
    check("dbl_instr", bus0.o_instr, 64'hC001_4008);
    check("dbl_valid", bus0.o_instr_valid, 1);

    // Ack and redirect in the same cycle
    bus0.i_instr_ready = 1'b1;
    tick();
    bus0.i_instr_ready = 1'b0;
    check("ar_addr0", bus0.o_imem_addr, 64'h400C);
    bus0.i_imem_ack = 1'b1; bus0.i_imem_data = 32'hBAD2_400C;
    bus0.i_branch_taken = 1'b1; bus0.i_branch_target = 64'h200;
    tick();
    bus0.i_imem_ack = 1'b0; bus0.i_branch_taken = 1'b0;
    check("ar_valid", bus0.o_instr_valid, 0);
    check("ar_addr",  bus0.o_imem_addr, 64'h200);
    check("ar_pc",    bus0.o_pc, 64'h200);
    check("ar_req",   bus0.o_imem_req, 1);
    bus0.i_imem_ack = 1'b1; bus0.i_imem_data = 32'hC002_0200;
    tick();
    bus0.i_imem_ack = 1'b0;
    check("ar_instr", bus0.o_instr, 64'hC002_0200);

    // Redirect in VALID beats stall
    bus0.i_stall = 1'b1; bus0.i_instr_ready = 1'b1;
    bus0.i_branch_taken = 1'b1; bus0.i_branch_target = 64'h7FF;
    tick();
    bus0.i_stall = 1'b0; bus0.i_instr_ready = 1'b0; bus0.i_branch_taken = 1'b0;
    check("vr_valid", bus0.o_instr_valid, 0);
    check("vr_addr",  bus0.o_imem_addr, 64'h7FC);
    check("vr_pc",    bus0.o_pc, 64'h7FC);

    // Asynchronous reset mid-VALID, then a late ack
    bus0.i_imem_ack = 1'b1; bus0.i_imem_data = 32'hC003_07FC;
    tick();
    bus0.i_imem_ack = 1'b0;
    check("ar0_valid", bus0.o_instr_valid, 1);
    #3 rst = 1'b1;
    #1;
    check("arst_pc",    bus0.o_pc, 64'h0);
    check("arst_addr",  bus0.o_imem_addr, 64'h0);
    check("arst_valid", bus0.o_instr_valid, 0);
    check("arst_req",   bus0.o_imem_req, 0);
    check("arst_instr", bus0.o_instr, 0);
    #1 rst = 1'b0;
    bus0.i_imem_ack = 1'b1; bus0.i_imem_data = 32'hBAD3_07FC;
    tick();
    bus0.i_imem_ack = 1'b0;
    check("late_valid", bus0.o_instr_valid, 0);
    check("late_req",   bus0.o_imem_req, 1);
    check("late_addr",  bus0.o_imem_addr, 64'h0);

    // Wrap from the top of the address space
    check("wrap_addr0", bus1.o_imem_addr, WRAP_VECTOR);
    check("wrap_req0",  bus1.o_imem_req, 1);
    bus1.i_imem_ack = 1'b1; bus1.i_imem_data = 32'hE000_0000;
    tick();
    bus1.i_imem_ack = 1'b0;
    check("wrap_valid", bus1.o_instr_valid, 1);
    check("wrap_pc0",   bus1.o_pc, WRAP_VECTOR);
    bus1.i_instr_ready = 1'b1;
    tick();
    bus1.i_instr_ready = 1'b0;
    check("wrap_addr", bus1.o_imem_addr, 64'h0);
    check("wrap_pc",   bus1.o_pc, 64'h0);

    // Redirect on the first edge out of reset
    rst = 1'b1;
    #2 rst = 1'b0;
    bus0.i_branch_taken = 1'b1; bus0.i_branch_target = 64'hABC1;
    tick();
    bus0.i_branch_taken = 1'b0;
    check("idle_br_pc",   bus0.o_pc, 64'hABC0);
    check("idle_br_addr", bus0.o_imem_addr, 64'hABC0);
    check("idle_br_req",  bus0.o_imem_req, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
